// File: rtl/masku_compress_seq.sv
// Purpose  : sequences mask-unit ALU/FPU result compression into DW-wide mask words.
// Latency  : last beat accepted at cycle t -> result at t+1 -> done_o one cycle after the final handshake.
// Backpress: alu_ready_o drops while an unconsumed mask word is held; result word holds until result_ready_i.
//
// Ports:
//   clk_i / rst_ni                 clock, synchronous active-low reset
//   vinsn_valid_i/_ready_o         one instruction at a time (vl, vsew latched on accept)
//   vinsn_vl_i, vinsn_vsew_i       element count, result SEW (0=EW8 .. 3=EW64)
//   alu_valid_i/_ready_o           compressed operand beats, already placed at vrf_pnt_o
//   alu_compressed_i               compressed beat data
//   vrf_pnt_o, vsew_o              mask-bit write pointer and latched SEW for the operand stage
//   result_valid_o/_ready_i        mask word handshake
//   result_o, result_last_o        mask word and last-of-instruction flag
//   done_o                         single-cycle retire pulse
module masku_compress_seq #(
    parameter  int NrLanes = 4,
    parameter  int VlWidth = 16,
    localparam int DW      = NrLanes * 64,
    localparam int PW      = $clog2(DW) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vinsn_valid_i,
    output logic               vinsn_ready_o,
    input  logic [VlWidth-1:0] vinsn_vl_i,
    input  logic [1:0]         vinsn_vsew_i,
    input  logic               alu_valid_i,
    output logic               alu_ready_o,
    input  logic [DW-1:0]      alu_compressed_i,
    output logic [PW-1:0]      vrf_pnt_o,
    output logic [1:0]         vsew_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [DW-1:0]      result_o,
    output logic               result_last_o,
    output logic               done_o
);

    // Element-count width: enough to hold DW/8 (elements per beat at EW8).
    localparam int EW = $clog2(DW / 8) + 1;
    localparam logic [EW-1:0] EMAX = EW'(DW / 8);
    localparam logic [1:0] EW8 = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [1:0]           vsew_q, vsew_d;
    logic [VlWidth-1:0]   rem_q, rem_d;
    logic [PW-1:0]        pnt_q, pnt_d;
    logic [DW-1:0]        acc_q, acc_d;
    logic [DW-1:0]        res_q, res_d;
    logic                 res_vld_q, res_vld_d;
    logic                 res_last_q, res_last_d;

    // ------------------------------------------------------------------
    // Per-beat datapath
    // ------------------------------------------------------------------
    logic [EW-1:0]        e_per_beat;
    logic [EW-1:0]        n_elem;
    logic [DW-1:0]        lo_mask;
    logic [DW-1:0]        beat_mask;
    logic [DW-1:0]        acc_upd;
    logic [PW-1:0]        pnt_nxt;
    logic [VlWidth-1:0]   rem_nxt;
    logic                 emit;
    logic                 beat_fire;

    // Elements carried by one beat shrink with SEW; the last beat may be partial.
    assign e_per_beat = EMAX >> vsew_q;
    assign n_elem     = (rem_q < {{(VlWidth-EW){1'b0}}, e_per_beat}) ? rem_q[EW-1:0] : e_per_beat;

    // Only bits [pnt, pnt+n) belong to this beat; everything else on the bus is ignored.
    assign lo_mask    = ~({DW{1'b1}} << n_elem);
    assign beat_mask  = lo_mask << pnt_q;
    assign acc_upd    = acc_q | (alu_compressed_i & beat_mask);

    assign pnt_nxt    = pnt_q + {{(PW-EW){1'b0}}, n_elem};
    assign rem_nxt    = rem_q - {{(VlWidth-EW){1'b0}}, n_elem};

    // E always divides DW, so the pointer lands exactly on DW when a word fills.
    assign emit       = (pnt_nxt == PW'(DW)) || (rem_nxt == '0);

    // A beat may only be taken when its possible emit has somewhere to go.
    assign alu_ready_o = (state_q == RUN) && (!res_vld_q || result_ready_i);
    assign beat_fire   = alu_valid_i && alu_ready_o;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        vsew_d     = vsew_q;
        rem_d      = rem_q;
        pnt_d      = pnt_q;
        acc_d      = acc_q;
        res_d      = res_q;
        res_vld_d  = res_vld_q;
        res_last_d = res_last_q;

        // Consumption first; a coincident emit below overrides it so valid stays high.
        if (res_vld_q && result_ready_i) begin
            res_vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (vinsn_valid_i) begin
                    vsew_d  = vinsn_vsew_i;
                    rem_d   = vinsn_vl_i;
                    pnt_d   = '0;
                    acc_d   = '0;
                    state_d = (vinsn_vl_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat_fire) begin
                    rem_d = rem_nxt;
                    if (emit) begin
                        res_d      = acc_upd;
                        res_vld_d  = 1'b1;
                        res_last_d = (rem_nxt == '0);
                        acc_d      = '0;
                        pnt_d      = '0;
                    end else begin
                        acc_d = acc_upd;
                        pnt_d = pnt_nxt;
                    end
                    if (rem_nxt == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final word was emitted on entry; wait for it to leave.
                if (res_vld_q && result_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vsew_q     <= EW8;
            rem_q      <= '0;
            pnt_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            res_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsew_q     <= vsew_d;
            rem_q      <= rem_d;
            pnt_q      <= pnt_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            res_last_q <= res_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign vinsn_ready_o  = (state_q == IDLE);
    assign vrf_pnt_o      = pnt_q;
    assign vsew_o         = vsew_q;
    assign result_valid_o = res_vld_q;
    assign result_o       = res_q;
    assign result_last_o  = res_last_q;
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_masku_compress_seq.sv
// Purpose  : randomized scoreboard bench for masku_compress_seq.
// Latency  : expected words are queued per instruction, popped on each result handshake.
// Backpress: result_ready_i is randomized or forced low to exercise stalls.
module tb_masku_compress_seq;

    localparam int DW = 256;
    localparam int PW = 9;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            vinsn_valid = 1'b0;
    logic            vinsn_ready;
    logic [15:0]     vinsn_vl = '0;
    logic [1:0]      vinsn_vsew = '0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [DW-1:0]   alu_dat = '0;
    logic [PW-1:0]   vrf_pnt;
    logic [1:0]      vsew;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [DW-1:0]   result;
    logic            result_last;
    logic            done;

    masku_compress_seq #(.NrLanes(4), .VlWidth(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .vinsn_valid_i    (vinsn_valid),
        .vinsn_ready_o    (vinsn_ready),
        .vinsn_vl_i       (vinsn_vl),
        .vinsn_vsew_i     (vinsn_vsew),
        .alu_valid_i      (alu_valid),
        .alu_ready_o      (alu_ready),
        .alu_compressed_i (alu_dat),
        .vrf_pnt_o        (vrf_pnt),
        .vsew_o           (vsew),
        .result_valid_o   (result_valid),
        .result_ready_i   (result_ready),
        .result_o         (result),
        .result_last_o    (result_last),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_hs_cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   force_lo = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Sink readiness, changed just after each edge.
    always @(posedge clk) begin
        #1;
        if (force_lo)      result_ready = 1'b0;
        else if (rand_rdy) result_ready = ($urandom_range(0, 3) != 0);
        else               result_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    exp_t          mon_e;
    logic          hold_chk = 1'b0;
    logic [DW-1:0] prev_dat;
    logic          prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", DW'(result_valid), DW'(1));
                chk("hold_data", result, prev_dat);
                chk("hold_last", DW'(result_last), DW'(prev_last));
            end
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected no word", result);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_data", result, mon_e.dat);
                    chk("word_last", DW'(result_last), DW'(mon_e.last));
                end
                last_hs_cyc = cyc;
            end
            hold_chk  = result_valid && !result_ready;
            prev_dat  = result;
            prev_last = result_last;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_vinsn_ready"}, DW'(vinsn_ready), DW'(1));
        chk({tag, "_alu_ready"}, DW'(alu_ready), DW'(0));
        chk({tag, "_vrf_pnt"}, DW'(vrf_pnt), DW'(0));
        chk({tag, "_vsew"}, DW'(vsew), DW'(0));
        chk({tag, "_result_valid"}, DW'(result_valid), DW'(0));
        chk({tag, "_result"}, result, '0);
        chk({tag, "_result_last"}, DW'(result_last), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
    endtask

    task automatic die(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected handshake", nm);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    endtask

    // One full instruction. Expected words come from the element-level model:
    // element i sits at mask bit i, and its bit is taken from beat i/E.
    task automatic run_insn(input int vl, input int sew, input bit ones, input bit gaps);
        int            e_cnt = 32 >> sew;
        int            nb    = (vl + e_cnt - 1) / e_cnt;
        int            nw    = (vl + DW - 1) / DW;
        int            t;
        int            acc_cyc;
        logic [DW-1:0] beats[$];
        exp_t          w;
        for (int k = 0; k < nb; k++) beats.push_back(ones ? {DW{1'b1}} : rnd_word());
        for (int wi = 0; wi < nw; wi++) begin
            w.dat  = '0;
            w.last = (wi == nw - 1);
            for (int b = 0; b < DW; b++) begin
                int i = wi * DW + b;
                if (i < vl) w.dat[b] = beats[i / e_cnt][b];
            end
            exp_q.push_back(w);
        end

        @(posedge clk); #1;
        vinsn_valid = 1'b1;
        vinsn_vl    = 16'(vl);
        vinsn_vsew  = 2'(sew);
        t = 0;
        do begin @(negedge clk); t++; end while (!vinsn_ready && t < 100);
        if (!vinsn_ready) die("vinsn_accept");
        acc_cyc = cyc;
        @(posedge clk); #1;
        vinsn_valid = 1'b0;
        vinsn_vl    = 16'($urandom);
        vinsn_vsew  = 2'($urandom);

        for (int k = 0; k < nb; k++) begin
            alu_valid = 1'b1;
            alu_dat   = beats[k];
            t = 0;
            do begin @(negedge clk); t++; end while (!alu_ready && t < 2000);
            if (!alu_ready) die("beat_accept");
            chk("vrf_pnt", DW'(vrf_pnt), DW'((k * e_cnt) % DW));
            if (k == 0) chk("vsew_latched", DW'(vsew), DW'(sew));
            @(posedge clk); #1;
            alu_valid = 1'b0;
            alu_dat   = rnd_word();
            if (gaps && k < nb - 1) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end

        if (nb > 0) begin
            @(negedge clk);
            chk("last_beat_to_valid", DW'(result_valid), DW'(1));
            chk("last_beat_flag", DW'(result_last), DW'(1));
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 2000);
        if (!done) die("done_wait");
        if (vl == 0) chk("done_after_vl0_accept", DW'(cyc - acc_cyc), DW'(1));
        else         chk("done_after_final_hs", DW'(cyc - last_hs_cyc), DW'(1));
        @(negedge clk);
        chk("done_single_cycle", DW'(done), DW'(0));
        chk("scoreboard_drained", DW'(exp_q.size()), DW'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // EW8 vl=64 all-ones: one word, 64 LSBs set.
        run_insn(64, 0, 1'b1, 1'b0);
        // EW64 vl=256: 64 beats, pointer walks in steps of 4.
        run_insn(256, 3, 1'b0, 1'b0);
        // EW8 vl=40 all-ones: bits above 40 must stay clear.
        run_insn(40, 0, 1'b1, 1'b0);
        // vl=0: no word, retire only.
        run_insn(0, 2, 1'b0, 1'b0);

        // EW16 vl=512 with sink stalled once the first word is out.
        fork
            run_insn(512, 1, 1'b0, 1'b0);
            begin
                force_lo = 1'b1;
                t = 0;
                do begin @(negedge clk); t++; end while (!result_valid && t < 500);
                if (!result_valid) die("stall_first_word");
                repeat (6) begin
                    @(negedge clk);
                    chk("stall_alu_ready", DW'(alu_ready), DW'(0));
                    chk("stall_valid", DW'(result_valid), DW'(1));
                end
                force_lo = 1'b0;
            end
        join

        // Reset after 3 of 8 beats: aborted instruction leaves no trace.
        @(posedge clk); #1;
        vinsn_valid = 1'b1;
        vinsn_vl    = 16'd256;
        vinsn_vsew  = 2'd0;
        @(negedge clk);
        chk("abort_accept", DW'(vinsn_ready), DW'(1));
        @(posedge clk); #1;
        vinsn_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1;
            alu_dat   = rnd_word();
            t = 0;
            do begin @(negedge clk); t++; end while (!alu_ready && t < 100);
            if (!alu_ready) die("abort_beat");
            @(posedge clk); #1;
        end
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrun_reset");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        alu_valid = 1'b0;
        run_insn(256, 0, 1'b0, 1'b1);

        // Randomized instructions with random beat gaps and sink backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int sew = $urandom_range(0, 3);
            int vl  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
            run_insn(vl, sew, 1'b0, 1'b1);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
